l2_request_buffer: RTL and testbench

Per-core request FIFO between the L1/L2 interface and the L2 cache arbiter. It accepts L2 request packets from the core's L1 side and presents them to the L2 arbiter in strict arrival order. Its ready output depends only on its own registered state. This breaks the combinational path from the arbiter's grant back into the core, and lets the core issue back-to-back requests while the arbiter is busy.

---
 rtl/l2_request_buffer_pkg.sv | 27 ++
 rtl/l2_request_buffer.sv | 93 +++++++++
 tb/tb_l2_request_buffer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/l2_request_buffer_pkg.sv
// Shared L2 request payload types for the L1/L2 request path.
package l2_request_buffer_pkg;

  localparam int unsigned L2_CORE_W = 2;
  localparam int unsigned L2_ID_W   = 8;
  localparam int unsigned L2_ADDR_W = 32;
  localparam int unsigned L2_DATA_W = 32;

  typedef enum logic [2:0] {
    L2_LOAD        = 3'd0,
    L2_LOAD_SYNC   = 3'd1,
    L2_STORE       = 3'd2,
    L2_STORE_SYNC  = 3'd3,
    L2_FLUSH       = 3'd4,
    L2_IINVALIDATE = 3'd5,
    L2_DINVALIDATE = 3'd6
  } l2req_op_t;

  typedef struct packed {
    logic [L2_CORE_W-1:0] core;
    l2req_op_t            op;
    logic [L2_ID_W-1:0]   id;
    logic [L2_ADDR_W-1:0] address;
    logic [L2_DATA_W-1:0] data;
  } l2req_packet_t;

endpackage

// File: rtl/l2_request_buffer.sv
// Per-core in-order request FIFO between the L1 side and the L2 arbiter.
// Ready and head-valid come from registered state only, so the arbiter's
// grant never reaches back into the core combinationally.
module l2_request_buffer
  import l2_request_buffer_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CORE_ID = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         l2i_request_valid,
  input  l2req_packet_t                l2i_request,
  output logic                         l2_ready,
  output logic                         l2bf_request_valid,
  output l2req_packet_t                l2bf_request,
  input  logic                         l2bf_ready,
  output logic [$clog2(DEPTH+1)-1:0]   l2bf_occupancy,
  output logic [$clog2(DEPTH+1)-1:0]   l2bf_high_water,
  output logic                         l2bf_perf_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  l2req_packet_t    storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occupancy;
  logic [OCC_W-1:0] occupancy_next;
  logic [OCC_W-1:0] high_water;
  logic             ready_q;
  logic             valid_q;
  logic             enq;
  logic             deq;

  assign enq = l2i_request_valid && ready_q;
  assign deq = valid_q && l2bf_ready;

  // Entry count after this edge; simultaneous enqueue and dequeue cancel.
  always_comb begin
    occupancy_next = occupancy;
    case ({enq, deq})
      2'b10:   occupancy_next = occupancy + OCC_W'(1);
      2'b01:   occupancy_next = occupancy - OCC_W'(1);
      default: occupancy_next = occupancy;
    endcase
  end

  // Pointers, count, ready/valid flags and high-water mark.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      high_water <= '0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      occupancy <= occupancy_next;
      ready_q   <= (occupancy_next != OCC_W'(DEPTH));
      valid_q   <= (occupancy_next != OCC_W'(0));
      if (occupancy_next > high_water) high_water <= occupancy_next;
    end
  end

  // Payload storage is intentionally left unreset; valid_q qualifies it.
  always_ff @(posedge clk) begin
    if (enq) storage[wr_ptr] <= l2i_request;
  end

  assign l2_ready           = ready_q;
  assign l2bf_request_valid = valid_q;
  assign l2bf_request       = storage[rd_ptr];
  assign l2bf_occupancy     = occupancy;
  assign l2bf_high_water    = high_water;
  assign l2bf_perf_full     = l2i_request_valid && !ready_q;

  // Never write into a full buffer.
  a_no_enq_full: assert property (@(posedge clk) disable iff (!reset)
    enq |-> (occupancy != OCC_W'(DEPTH)));

  // Only this core's requests may enter its buffer.
  a_core_id: assert property (@(posedge clk) disable iff (!reset)
    enq |-> (l2i_request.core == L2_CORE_W'(CORE_ID)));

  // Head packet holds while the arbiter stalls it.
  a_head_stable: assert property (@(posedge clk) disable iff (!reset)
    (l2bf_request_valid && !l2bf_ready) |=> $stable(l2bf_request));

endmodule

// File: tb/tb_l2_request_buffer.sv
// Directed bench for l2_request_buffer with a queue-based reference model.
module tb_l2_request_buffer;
  import l2_request_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          l2i_request_valid = 1'b0;
  l2req_packet_t l2i_request = '0;
  logic          l2_ready;
  logic          l2bf_request_valid;
  l2req_packet_t l2bf_request;
  logic          l2bf_ready = 1'b0;
  logic [OCC_W-1:0] l2bf_occupancy;
  logic [OCC_W-1:0] l2bf_high_water;
  logic          l2bf_perf_full;

  l2_request_buffer #(.DEPTH(DEPTH), .CORE_ID(0)) dut (
    .clk                (clk),
    .reset              (reset),
    .l2i_request_valid  (l2i_request_valid),
    .l2i_request        (l2i_request),
    .l2_ready           (l2_ready),
    .l2bf_request_valid (l2bf_request_valid),
    .l2bf_request       (l2bf_request),
    .l2bf_ready         (l2bf_ready),
    .l2bf_occupancy     (l2bf_occupancy),
    .l2bf_high_water    (l2bf_high_water),
    .l2bf_perf_full     (l2bf_perf_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a plain queue of packets plus the ready the core saw.
  l2req_packet_t mq[$];
  logic          m_ready = 1'b0;
  int            m_hw = 0;
  logic [7:0]    out_log[$];
  logic [7:0]    exp_log[$];

  always @(posedge clk) begin
    logic m_enq;
    logic m_deq;
    if (!reset) begin
      mq.delete();
      m_ready = 1'b0;
      m_hw    = 0;
    end else begin
      if (l2bf_request_valid && l2bf_ready) out_log.push_back(l2bf_request.id);
      m_enq = l2i_request_valid && m_ready;
      m_deq = (mq.size() != 0) && l2bf_ready;
      if (m_deq) void'(mq.pop_front());
      if (m_enq) mq.push_back(l2i_request);
      m_ready = (mq.size() != DEPTH);
      if (mq.size() > m_hw) m_hw = mq.size();
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    check("ready", 128'(l2_ready), 128'(m_ready));
    check("valid", 128'(l2bf_request_valid), 128'(mq.size() != 0));
    check("occupancy", 128'(l2bf_occupancy), 128'(mq.size()));
    check("high_water", 128'(l2bf_high_water), 128'(m_hw));
    check("perf_full", 128'(l2bf_perf_full), 128'(l2i_request_valid && !m_ready));
    if (mq.size() != 0) check("head", 128'(l2bf_request), 128'(mq[0]));
  end

  function automatic l2req_packet_t mk(input logic [7:0] id, input l2req_op_t op);
    l2req_packet_t p;
    p.core    = '0;
    p.op      = op;
    p.id      = id;
    p.address = {24'h10_0000, id};
    p.data    = {id, 24'hA5_5A00} ^ 32'(id);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a packet until it is taken; optional random arbiter stalls.
  task automatic send_hold(input l2req_packet_t p, input bit rnd);
    int budget = 50;
    logic took;
    l2i_request_valid = 1'b1;
    l2i_request       = p;
    forever begin
      if (rnd) l2bf_ready = 1'($urandom_range(0, 1));
      took = l2_ready;
      step();
      if (took) break;
      budget--;
      if (budget == 0) begin
        check("send_timeout", 128'(0), 128'(1));
        break;
      end
    end
    l2i_request_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int budget = 100;
    while (l2bf_request_valid && budget > 0) begin
      l2bf_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      budget--;
    end
    if (budget == 0) check("drain_timeout", 128'(0), 128'(1));
    l2bf_ready = 1'b0;
  endtask

  initial begin
    l2req_op_t ops[4];
    ops[0] = L2_STORE; ops[1] = L2_FLUSH; ops[2] = L2_LOAD_SYNC; ops[3] = L2_DINVALIDATE;

    // Reset held, then released.
    repeat (3) step();
    check("rst_ready", 128'(l2_ready), 128'(0));
    check("rst_valid", 128'(l2bf_request_valid), 128'(0));
    check("rst_occ", 128'(l2bf_occupancy), 128'(0));
    reset = 1'b1;
    check("rel_ready_pre", 128'(l2_ready), 128'(0));
    step();
    check("rel_ready", 128'(l2_ready), 128'(1));
    check("rel_valid", 128'(l2bf_request_valid), 128'(0));

    // Fill with arbiter stalled; id 4 must be held.
    l2bf_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      l2i_request_valid = 1'b1;
      l2i_request = mk(8'(i), L2_LOAD);
      step();
      exp_log.push_back(8'(i));
    end
    check("full_ready", 128'(l2_ready), 128'(0));
    check("full_occ", 128'(l2bf_occupancy), 128'(4));
    check("full_hw", 128'(l2bf_high_water), 128'(4));
    l2i_request = mk(8'd4, L2_LOAD);
    check("held_perf0", 128'(l2bf_perf_full), 128'(1));
    step();
    check("held_perf1", 128'(l2bf_perf_full), 128'(1));
    check("held_occ", 128'(l2bf_occupancy), 128'(4));
    check("held_head", 128'(l2bf_request.id), 128'(0));
    l2bf_ready = 1'b1;
    step();
    l2bf_ready = 1'b0;
    check("deq_occ", 128'(l2bf_occupancy), 128'(3));
    check("deq_ready", 128'(l2_ready), 128'(1));
    check("deq_head", 128'(l2bf_request.id), 128'(1));
    step();
    exp_log.push_back(8'd4);
    l2i_request_valid = 1'b0;
    check("id4_occ", 128'(l2bf_occupancy), 128'(4));
    drain(1'b0);

    // Streaming across pointer wrap with the arbiter always ready.
    l2bf_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      l2i_request_valid = 1'b1;
      l2i_request = mk(8'(16 + i), L2_LOAD);
      if (i == 0) check("stream_no_pass", 128'(l2bf_request_valid), 128'(0));
      step();
      exp_log.push_back(8'(16 + i));
      check("stream_occ", 128'(l2bf_occupancy), 128'(1));
      check("stream_head", 128'(l2bf_request.id), 128'(16 + i));
    end
    l2i_request_valid = 1'b0;
    step();
    check("stream_empty", 128'(l2bf_occupancy), 128'(0));
    l2bf_ready = 1'b0;

    // Mixed packet types with random arbiter stalls.
    for (int i = 0; i < 8; i++) begin
      l2req_packet_t p;
      p = mk(8'(32 + i), ops[i % 4]);
      p.address = $urandom;
      p.data    = $urandom;
      send_hold(p, 1'b1);
      exp_log.push_back(8'(32 + i));
    end
    drain(1'b1);

    // Reset with three packets buffered; nothing stale may emerge.
    l2bf_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_hold(mk(8'(48 + i), L2_STORE_SYNC), 1'b0);
    check("pre_rst_occ", 128'(l2bf_occupancy), 128'(3));
    reset = 1'b0;
    step();
    check("mid_rst_occ", 128'(l2bf_occupancy), 128'(0));
    check("mid_rst_valid", 128'(l2bf_request_valid), 128'(0));
    check("mid_rst_hw", 128'(l2bf_high_water), 128'(0));
    check("mid_rst_ready", 128'(l2_ready), 128'(0));
    reset = 1'b1;
    l2bf_ready = 1'b1;
    repeat (4) step();
    check("post_rst_valid", 128'(l2bf_request_valid), 128'(0));
    l2bf_ready = 1'b0;

    // Output order against the hand-built expected id list.
    check("log_len", 128'(out_log.size()), 128'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < out_log.size(); i++)
      check("log_id", 128'(out_log[i]), 128'(exp_log[i]));

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
